// File: rtl/sub_top_conv_engine_if.sv
// Load/control/result bundle between the DMA+sequencer side (master) and the conv engine (slave).
interface sub_top_conv_engine_if;
    logic              we_IFM;
    logic              we_weight;
    logic [31:0]       addr;
    logic [31:0]       data_in_IFM;
    logic [15:0][31:0] data_in_Weight;
    logic              cal_start;
    logic [15:0]       PE_en;
    logic [15:0]       PE_finish;
    logic [15:0]       valid;
    logic [15:0][7:0]  OFM_k;
    logic [31:0]       OFM;

    modport master (
        output we_IFM, we_weight, addr, data_in_IFM, data_in_Weight,
        output cal_start, PE_en, PE_finish,
        input  valid, OFM_k, OFM
    );

    modport slave (
        input  we_IFM, we_weight, addr, data_in_IFM, data_in_Weight,
        input  cal_start, PE_en, PE_finish,
        output valid, OFM_k, OFM
    );
endinterface

// File: rtl/sub_top_conv_engine.sv
// Conv sub-top: shared IFM window stream into 16 int8 3x3x16 MAC PEs; CONV_RELU_EN selects ReLU clamp.
// Latency: 36 taps, first MAC 2 cycles after job start, result 1 cycle after PE_finish; no backpressure.
module sub_top_conv_engine #(
    parameter int IFM_DEPTH = 12544,
    parameter int W_DEPTH   = 72,
    parameter int IFM_W     = 58,
    parameter int CH_WORDS  = 4,
    parameter int OUT_SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    sub_top_conv_engine_if.slave   bus
);
    localparam int NPE   = 16;
    localparam int NTAPS = 36;
    localparam int IA_W  = $clog2(IFM_DEPTH);
    localparam int WA_W  = $clog2(W_DEPTH);
    localparam int POS_W = $clog2(IFM_W);

    typedef enum logic {GEN_IDLE, GEN_RUN} gen_state_t;

    gen_state_t                   state, state_nxt;
    logic [5:0]                   tap, tap_nxt;
    logic                         issue, rd_vld;
    logic [1:0]                   tr, tc, tw;
    logic [POS_W-1:0]             row, col;
    logic [NPE-1:0]               armed, armed_nxt, start_vec, fin_vec;
    logic                         job_start, fin_any_q;
    logic [31:0]                  ifm_raddr;
    logic [31:0]                  ifm_mem [IFM_DEPTH];
    logic [31:0]                  w_mem [NPE][W_DEPTH];
    logic [31:0]                  ifm_q;
    logic [NPE-1:0][31:0]         w_q;
    logic signed [NPE-1:0][31:0]  acc;
    logic [NPE-1:0]               valid_q;
    logic [NPE-1:0][7:0]          ofm_q;

    function automatic logic signed [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [7:0]  x, y;
        logic signed [15:0] p;
        logic signed [31:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            p = x * y;
            s = s + p;
        end
        return s;
    endfunction

    function automatic logic [7:0] finalize(input logic signed [31:0] acc_v);
        logic signed [31:0] v;
        v = acc_v >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
        if (v < 0)        return 8'h00;
        else if (v > 255) return 8'hFF;
        else              return v[7:0];
`else
        if (v < -128)     return 8'h80;
        else if (v > 127) return 8'h7F;
        else              return v[7:0];
`endif
    endfunction

    // A finish in the same cycle as an enable suppresses that PE's start.
    assign start_vec = {NPE{bus.cal_start}} & bus.PE_en & ~bus.PE_finish;
    assign fin_vec   = {NPE{bus.cal_start}} & bus.PE_finish & armed;
    assign job_start = |start_vec;
    assign armed_nxt = bus.cal_start ? ((armed & ~fin_vec) | start_vec) : '0;

    always_comb begin
        tw = tap[1:0];
        if (tap >= 6'd24)      tr = 2'd2;
        else if (tap >= 6'd12) tr = 2'd1;
        else                   tr = 2'd0;
        tc = 2'(tap[5:2] - 4'(3 * tr));
    end

    assign ifm_raddr = ((32'(row) + 32'(tr)) * 32'(IFM_W) + 32'(col) + 32'(tc)) * 32'(CH_WORDS) + 32'(tw);

    // Restart and abort both suppress the read issued this cycle so stale taps never reach the PEs.
    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        issue     = 1'b0;
        if (!bus.cal_start) begin
            state_nxt = GEN_IDLE;
        end else if (job_start) begin
            state_nxt = GEN_RUN;
            tap_nxt   = '0;
        end else if (state == GEN_RUN) begin
            issue   = 1'b1;
            tap_nxt = tap + 6'd1;
            if (tap == 6'(NTAPS - 1) || armed_nxt == '0)
                state_nxt = GEN_IDLE;
        end
    end

    // Buffers: read-first, no reset so contents survive a mid-job reset.
    always_ff @(posedge clk) begin
        if (bus.we_IFM && bus.addr < 32'(IFM_DEPTH))
            ifm_mem[bus.addr[IA_W-1:0]] <= bus.data_in_IFM;
        ifm_q <= (ifm_raddr < 32'(IFM_DEPTH)) ? ifm_mem[ifm_raddr[IA_W-1:0]] : '0;
        for (int k = 0; k < NPE; k++) begin
            if (bus.we_weight && bus.addr < 32'(W_DEPTH))
                w_mem[k][bus.addr[WA_W-1:0]] <= bus.data_in_Weight[k];
            w_q[k] <= w_mem[k][WA_W'(tap)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= GEN_IDLE;
            tap       <= '0;
            rd_vld    <= 1'b0;
            row       <= '0;
            col       <= '0;
            fin_any_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tap       <= tap_nxt;
            rd_vld    <= issue;
            fin_any_q <= |fin_vec;
            if ((|fin_vec) && !fin_any_q) begin
                if (col == POS_W'(IFM_W - 3)) begin
                    col <= '0;
                    row <= (row == POS_W'(IFM_W - 3)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            armed   <= '0;
            valid_q <= '0;
            ofm_q   <= '0;
        end else begin
            armed   <= armed_nxt;
            valid_q <= fin_vec;
            for (int k = 0; k < NPE; k++) begin
                if (start_vec[k])
                    acc[k] <= '0;
                else if (rd_vld && armed[k] && !fin_vec[k])
                    acc[k] <= acc[k] + dot4(ifm_q, w_q[k]);
                if (fin_vec[k])
                    ofm_q[k] <= finalize(acc[k]);
            end
        end
    end

    assign bus.valid = valid_q;
    assign bus.OFM_k = ofm_q;
    assign bus.OFM   = {ofm_q[0], ofm_q[1], ofm_q[2], ofm_q[3]};
endmodule

// File: tb/tb_sub_top_conv_engine.sv
// Randomised scoreboard bench for sub_top_conv_engine with an arithmetic reference model.
module tb_sub_top_conv_engine;
    localparam int IFM_DEPTH = 12544;
    localparam int W_DEPTH   = 72;
    localparam int IFM_W     = 58;
    localparam int CH_WORDS  = 4;
    localparam int OUT_SHIFT = 0;

    typedef struct packed {
        logic [15:0]      mask;
        logic [15:0][7:0] ofm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sub_top_conv_engine_if bus();
    sub_top_conv_engine dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0]      ifm_m [IFM_DEPTH];
    logic [31:0]      w_m [16][W_DEPTH];
    logic [15:0][7:0] last_ofm;
    int               row_m, col_m;
    exp_t             exp_q[$];
    int               checks, errors;

    function automatic int window_sum(int k, int n);
        int s = 0;
        for (int j = 0; j < n; j++) begin
            int r = j / 12;
            int c = (j / 4) % 3;
            int w = j % 4;
            int a = ((row_m + r) * IFM_W + col_m + c) * CH_WORDS + w;
            logic [31:0] x;
            logic [31:0] y;
            x = (a < IFM_DEPTH) ? ifm_m[a] : 32'h0;
            y = w_m[k][j];
            for (int b = 0; b < 4; b++) begin
                byte p, q;
                p = x[31-8*b -: 8];
                q = y[31-8*b -: 8];
                s += int'(p) * int'(q);
            end
        end
        return s;
    endfunction

    function automatic logic [7:0] clamp8(int s);
        int v = s >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
        if (v < 0)   return 8'h00;
        if (v > 255) return 8'hFF;
`else
        if (v < -128) return 8'h80;
        if (v > 127)  return 8'h7F;
`endif
        return 8'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ifm(int a, logic [31:0] d);
        bus.we_IFM      = 1'b1;
        bus.addr        = 32'(a);
        bus.data_in_IFM = d;
        ifm_m[a]        = d;
        tick();
        bus.we_IFM      = 1'b0;
    endtask

    task automatic load_weights(bit rnd, logic [31:0] v);
        bus.we_weight = 1'b1;
        for (int a = 0; a < W_DEPTH; a++) begin
            bus.addr = 32'(a);
            for (int k = 0; k < 16; k++) begin
                w_m[k][a] = rnd ? $urandom : v;
                bus.data_in_Weight[k] = w_m[k][a];
            end
            tick();
        end
        bus.we_weight = 1'b0;
    endtask

    task automatic fill_window(logic [31:0] v);
        for (int j = 0; j < 36; j++)
            write_ifm(((row_m + j / 12) * IFM_W + col_m + (j / 4) % 3) * CH_WORDS + j % 4, v);
    endtask

    // Start with PE_en at edge c0, finish at edge c0+d; products land on edges c0+2 .. c0+37.
    task automatic run_job(logic [15:0] en, logic [15:0] fin, int d);
        exp_t e;
        int   n;
        n = d - 2;
        if (n < 0)  n = 0;
        if (n > 36) n = 36;
        bus.PE_en = en;
        tick();
        bus.PE_en = '0;
        repeat (d - 1) tick();
        e.mask = en & fin;
        for (int k = 0; k < 16; k++) begin
            if (e.mask[k]) last_ofm[k] = clamp8(window_sum(k, n));
        end
        e.ofm = last_ofm;
        if (e.mask != '0) begin
            exp_q.push_back(e);
            if (col_m == IFM_W - 3) begin
                col_m = 0;
                row_m = (row_m == IFM_W - 3) ? 0 : row_m + 1;
            end else begin
                col_m++;
            end
        end
        bus.PE_finish = fin;
        tick();
        bus.PE_finish = '0;
        tick();
    endtask

    task automatic drain(string name);
        int budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results still outstanding, want 0", name, exp_q.size());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && (|bus.valid)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got valid=%h, want none", bus.valid);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.valid !== e.mask) begin
                        errors++;
                        $display("FAIL valid_mask: got %h, want %h", bus.valid, e.mask);
                    end
                    checks++;
                    if (bus.OFM_k !== e.ofm) begin
                        errors++;
                        $display("FAIL ofm_k: got %h, want %h", bus.OFM_k, e.ofm);
                    end
                    checks++;
                    if (bus.OFM !== {e.ofm[0], e.ofm[1], e.ofm[2], e.ofm[3]}) begin
                        errors++;
                        $display("FAIL ofm_packed: got %h, want %h", bus.OFM, {e.ofm[0], e.ofm[1], e.ofm[2], e.ofm[3]});
                    end
                end
            end
        end
    end

    initial begin : stim
        checks = 0;
        errors = 0;
        row_m = 0;
        col_m = 0;
        last_ofm = '0;
        bus.we_IFM = 1'b0;
        bus.we_weight = 1'b0;
        bus.addr = '0;
        bus.data_in_IFM = '0;
        bus.data_in_Weight = '0;
        bus.cal_start = 1'b1;
        bus.PE_en = '0;
        bus.PE_finish = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        checks += 3;
        if (bus.valid !== '0) begin errors++; $display("FAIL reset_valid: got %h, want 0", bus.valid); end
        if (bus.OFM_k !== '0) begin errors++; $display("FAIL reset_ofm_k: got %h, want 0", bus.OFM_k); end
        if (bus.OFM !== '0)   begin errors++; $display("FAIL reset_ofm: got %h, want 0", bus.OFM); end

        for (int a = 0; a < IFM_DEPTH; a++) write_ifm(a, $urandom);
        load_weights(1'b1, '0);
        run_job(16'hFFFF, 16'hFFFF, 40);

        // All-ones full job, all-ones against -1 weights, then a 10-tap partial sum.
        fill_window(32'h01010101);
        load_weights(1'b0, 32'h01010101);
        run_job(16'hFFFF, 16'hFFFF, 40);
        fill_window(32'h01010101);
        load_weights(1'b0, 32'hFFFFFFFF);
        run_job(16'hFFFF, 16'hFFFF, 40);
        fill_window(32'h01010101);
        load_weights(1'b0, 32'h01010101);
        run_job(16'hFFFF, 16'hFFFF, 12);
        drain("directed");

        load_weights(1'b1, '0);
        for (int i = 0; i < 12; i++) begin
            logic [15:0] m;
            m = 16'($urandom_range(1, 16'hFFFF));
            run_job(m, m, $urandom_range(1, 45));
        end
        run_job(16'h0001, 16'hFFFF, 40);
        drain("random_jobs");

        bus.cal_start = 1'b0;
        run_job(16'h0000, 16'h0000, 1);
        bus.PE_en = 16'hFFFF;
        tick();
        bus.PE_en = '0;
        repeat (40) tick();
        bus.PE_finish = 16'hFFFF;
        tick();
        bus.PE_finish = '0;
        repeat (3) tick();
        checks++;
        if (bus.OFM_k !== last_ofm) begin
            errors++;
            $display("FAIL cal_off_hold: got %h, want %h", bus.OFM_k, last_ofm);
        end

        bus.cal_start = 1'b1;
        bus.PE_en = 16'hFFFF;
        tick();
        bus.PE_en = '0;
        repeat (10) tick();
        bus.cal_start = 1'b0;
        repeat (2) tick();
        bus.PE_finish = 16'hFFFF;
        tick();
        bus.PE_finish = '0;
        bus.cal_start = 1'b1;
        tick();
        bus.PE_finish = 16'hFFFF;
        tick();
        bus.PE_finish = '0;
        tick();
        run_job(16'hFFFF, 16'hFFFF, 40);
        drain("abort");

        bus.PE_en = 16'hFFFF;
        tick();
        bus.PE_en = '0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        checks += 3;
        if (bus.valid !== '0) begin errors++; $display("FAIL midreset_valid: got %h, want 0", bus.valid); end
        if (bus.OFM_k !== '0) begin errors++; $display("FAIL midreset_ofm_k: got %h, want 0", bus.OFM_k); end
        if (bus.OFM !== '0)   begin errors++; $display("FAIL midreset_ofm: got %h, want 0", bus.OFM); end
        tick();
        reset = 1'b0;
        row_m = 0;
        col_m = 0;
        last_ofm = '0;
        tick();

        // Job 1 after reset, 55 zero-length jobs, then job 57 lands on row 1 col 0.
        run_job(16'hFFFF, 16'hFFFF, 40);
        for (int i = 0; i < 55; i++) run_job(16'hFFFF, 16'hFFFF, 1);
        run_job(16'hFFFF, 16'hFFFF, 40);
        drain("row_advance");
        for (int i = 57; i < 3136; i++) run_job(16'hFFFF, 16'hFFFF, 1);
        run_job(16'hFFFF, 16'hFFFF, 40);
        drain("window_wrap");

        repeat (5) tick();
        drain("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
